// File: rtl/float_div_iter.sv
// Iterative IEEE-754 single-precision divider: radix-2 restoring mantissa
// division (one quotient bit per cycle), round to nearest even, flush/saturate.
module float_div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] floatA,
  input  logic [31:0] floatB,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t      state;
  logic        sgn;
  logic [7:0]  ea, eb;
  logic [24:0] rem;
  logic [23:0] dvs;
  logic [26:0] q;
  logic [4:0]  cnt;
  logic        spec;
  logic [31:0] spec_res;

  logic [24:0] diff;
  logic        ge;
  logic [22:0] mant;
  logic        guard, sticky, adj, rnd, inc;
  logic [23:0] mant_inc;
  logic signed [9:0] e;
  logic [31:0] res;

  assign ge   = rem >= {1'b0, dvs};
  assign diff = rem - {1'b0, dvs};

  always_comb begin
    mant   = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    adj    = 1'b0;
    if (q[26]) begin
      mant   = q[25:3];
      guard  = q[2];
      sticky = (|q[1:0]) | (rem != '0);
    end else begin
      mant   = q[24:2];
      guard  = q[1];
      sticky = q[0] | (rem != '0);
      adj    = 1'b1;
    end
    rnd      = guard & (sticky | mant[0]);
    // An all-ones mantissa rounding up wraps to zero and bumps the exponent.
    mant_inc = {1'b0, mant} + {23'd0, rnd};
    inc      = mant_inc[23];
    e        = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
             - $signed({9'd0, adj}) + $signed({9'd0, inc});
    if (spec)            res = spec_res;
    else if (e >= 10'sd255) res = {sgn, 8'hFF, 23'h0};
    else if (e <= 10'sd0)   res = 32'h0;
    else                 res = {sgn, e[7:0], mant_inc[22:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= 32'h0;
      sgn      <= 1'b0;
      ea       <= '0;
      eb       <= '0;
      rem      <= '0;
      dvs      <= '0;
      q        <= '0;
      cnt      <= '0;
      spec     <= 1'b0;
      spec_res <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            busy <= 1'b1;
            sgn  <= floatA[31] ^ floatB[31];
            ea   <= floatA[30:23];
            eb   <= floatB[30:23];
            // Special results still pass through ROUND so they land one edge later.
            if (floatA[30:23] == 8'h00) begin
              spec     <= 1'b1;
              spec_res <= 32'h0;
              state    <= ROUND;
            end else if (floatB[30:23] == 8'h00) begin
              spec     <= 1'b1;
              spec_res <= {floatA[31] ^ floatB[31], 8'hFF, 23'h0};
              state    <= ROUND;
            end else begin
              spec  <= 1'b0;
              rem   <= {2'b01, floatA[22:0]};
              dvs   <= {1'b1, floatB[22:0]};
              q     <= '0;
              cnt   <= '0;
              state <= DIV;
            end
          end
        end
        DIV: begin
          rem <= ge ? {diff[23:0], 1'b0} : {rem[23:0], 1'b0};
          q   <= {q[25:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd26) state <= ROUND;
        end
        ROUND: begin
          quotient <= res;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_div_iter.sv
// Directed-table plus random self-checking bench for float_div_iter.
module tb_float_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] floatA = '0, floatB = '0;
  logic        busy, done;
  logic [31:0] quotient;

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, accepted = 0;

  float_div_iter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .floatA(floatA), .floatB(floatB),
    .busy(busy), .done(done), .quotient(quotient)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference of the division rules using integer division of the mantissas.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [63:0] num, qq, rm;
    logic [26:0] q27;
    logic [23:0] m;
    logic        g, st, adj;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 0) return 32'h0;
    if (b[30:23] == 0) return {s, 8'hFF, 23'h0};
    num = {40'd0, 1'b1, a[22:0]} << 26;
    qq  = num / {40'd0, 1'b1, b[22:0]};
    rm  = num % {40'd0, 1'b1, b[22:0]};
    q27 = qq[26:0];
    if (q27[26]) begin
      m = {1'b0, q27[25:3]}; g = q27[2]; st = (q27[1:0] != 0) || (rm != 0); adj = 0;
    end else begin
      m = {1'b0, q27[24:2]}; g = q27[1]; st = q27[0] || (rm != 0); adj = 1;
    end
    if (g && (st || m[0])) m = m + 1;
    e = int'(a[30:23]) - int'(b[30:23]) + 127 - int'(adj) + int'(m[23]);
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return 32'h0;
    return {s, e[7:0], m[22:0]};
  endfunction

  // Issue one op, wait for done (bounded), check result, latency and pulse width.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int n;
    floatA = a; floatB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    accepted++;
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_q"}, quotient, exp);
    chk({name, "_lat"}, n, lat);
    chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 28};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28};
    vecs[2]  = '{32'hC0F00000, 32'h40200000, 32'hC0400000, 28};
    vecs[3]  = '{32'h00000000, 32'h40000000, 32'h00000000, 1};
    vecs[4]  = '{32'hC0000000, 32'h00000000, 32'hFF800000, 1};
    vecs[5]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1};
    vecs[6]  = '{32'h00400000, 32'hC0000000, 32'h00000000, 1};
    vecs[7]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 28};
    vecs[8]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 28};
    vecs[9]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 28};
    vecs[10] = '{32'h40400000, 32'hC0000000, 32'hBFC00000, 28};

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Start pulsed mid-operation must be ignored.
    begin
      int n;
      floatA = 32'h40C00000; floatB = 32'h40000000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; accepted++;
      n = 0;
      repeat (4) begin @(posedge clk); #1; n++; end
      floatA = 32'h3F800000; floatB = 32'h40400000; start = 1'b1;
      @(posedge clk); #1; n++;
      start = 1'b0;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      chk("ign_q", quotient, 32'h40400000);
      chk("ign_lat", n, 28);
      @(posedge clk); #1;
      repeat (35) begin
        @(posedge clk); #1;
        n_chk++;
        if (busy || done) begin
          n_fail++;
          $display("FAIL ign_restart: busy=%0b done=%0b expected 0", busy, done);
        end
      end
    end

    // Reset mid-operation aborts without a done pulse.
    begin
      int dc;
      floatA = 32'h3F800000; floatB = 32'h40400000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dc = done_cnt;
      repeat (10) begin @(posedge clk); #1; end
      rst_n = 1'b0; #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_q", quotient, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (30) begin @(posedge clk); #1; end
      chk("abort_nodone", done_cnt, dc);
    end
    do_op("after_rst", 32'h40400000, 32'h40000000, 32'h3FC00000, 28);

    // Random normal operands against the reference model.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a, b;
      a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      do_op($sformatf("rnd%0d_%h_%h", i, a, b), a, b, model(a, b), 28);
    end

    chk("done_count", done_cnt, accepted);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
